// File: rtl/conv_pkg.sv
// Shared types and default sizes for the convolution window scheduler.
package conv_pkg;
  localparam int CNT_W   = 8;
  localparam int OFM_W   = 13;
  localparam int ENG_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/conv_res_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module conv_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 21,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign do_pop     = pop & head_valid;
  assign do_push    = push & (!full | do_pop);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // NOTE: storage is deliberately not reset; head_data is masked while empty so no X escapes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/conv_window_scheduler.sv
// Sequences one convolution job: weight load, credit-gated window issue, result collection.
// Credit counts in-flight engine results so a returning result always has a FIFO slot.
module conv_window_scheduler #(
  parameter int CNT_W      = conv_pkg::CNT_W,
  parameter int FIFO_DEPTH = 4,
  parameter int ENG_LAT    = conv_pkg::ENG_LAT,
  parameter int OFM_W      = conv_pkg::OFM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_win,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             w_src_valid,
  output logic             w_src_ready,
  input  logic             win_valid,
  output logic             win_ready,
  output logic             eng_weight_valid,
  output logic             eng_in_valid,
  input  logic             eng_out_valid,
  input  logic [OFM_W-1:0] eng_ofm,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OFM_W-1:0] res_data,
  output logic [CNT_W-1:0] res_idx
);
  import conv_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                   state;
  logic [CNT_W-1:0]         num_lat;
  logic [CNT_W-1:0]         issued;
  logic [CNT_W-1:0]         idx_ctr;
  logic [CW-1:0]            inflight;
  logic [CW-1:0]            fifo_count;
  logic [CW:0]              occupancy;
  logic                     fifo_full;
  logic                     credit_ok;
  logic                     pop;
  logic                     ret_ok;
  logic [CNT_W+OFM_W-1:0]   head;

  assign occupancy        = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok        = occupancy < (CW+1)'(FIFO_DEPTH);
  assign w_src_ready      = (state == ST_LOAD_W);
  assign eng_weight_valid = w_src_valid & w_src_ready;
  assign win_ready        = (state == ST_STREAM) && credit_ok && (issued < num_lat);
  assign eng_in_valid     = win_valid & win_ready;
  assign pop              = res_valid & res_ready;
  assign ret_ok           = eng_out_valid && (inflight != '0) && (!fifo_full || pop);
  assign {res_idx, res_data} = head;

  conv_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CNT_W + OFM_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (ret_ok),
    .push_data  ({idx_ctr, eng_ofm}),
    .pop        (res_ready),
    .head_valid (res_valid),
    .head_data  (head),
    .count      (fifo_count),
    .full       (fifo_full)
  );

  // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      num_lat  <= '0;
      issued   <= '0;
      idx_ctr  <= '0;
      inflight <= '0;
    end else begin
      done <= 1'b0;
      if (eng_out_valid && !ret_ok) err <= 1'b1;
      if (eng_in_valid) issued <= issued + 1'b1;
      if (ret_ok) idx_ctr <= idx_ctr + 1'b1;
      case ({eng_in_valid, ret_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase

      case (state)
        ST_IDLE: begin
          if (start) begin
            num_lat <= num_win;
            issued  <= '0;
            idx_ctr <= '0;
            // An empty job only pulses done; busy stays low for it.
            if (num_win == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_LOAD_W;
              busy  <= 1'b1;
            end
          end
        end
        ST_LOAD_W: if (w_src_valid) state <= ST_STREAM;
        ST_STREAM: if (issued == num_lat) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (inflight == '0 && !res_valid) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(eng_weight_valid && eng_in_valid));
  a_inflight_max: assert property (@(posedge clk) disable iff (!rst_n)
    inflight <= CW'(ENG_LAT + 1));
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: models the sources, a 2-cycle dot-product engine and the sink,
// and scores each job against per-window sums computed straight from the stored operands.
module tb_conv_window_scheduler;
  import conv_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int NTAP       = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_win = '0;
  logic             busy, done, err;
  logic             w_src_valid, w_src_ready, win_valid, win_ready;
  logic             eng_weight_valid, eng_in_valid, eng_out_valid;
  logic [OFM_W-1:0] eng_ofm, res_data;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [CNT_W-1:0] res_idx;

  int tests_run = 0;
  int tests_failed = 0;

  conv_window_scheduler #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ENG_LAT    (ENG_LAT),
    .OFM_W      (OFM_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .num_win          (num_win),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .w_src_valid      (w_src_valid),
    .w_src_ready      (w_src_ready),
    .win_valid        (win_valid),
    .win_ready        (win_ready),
    .eng_weight_valid (eng_weight_valid),
    .eng_in_valid     (eng_in_valid),
    .eng_out_valid    (eng_out_valid),
    .eng_ofm          (eng_ofm),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_idx          (res_idx)
  );

  always #5 clk = ~clk;

  // Job operands, source state and engine model
  logic [3:0]       weights [NTAP];
  logic [3:0]       win_mem [256][NTAP];
  logic [3:0]       eng_w   [NTAP];
  int               job_n = 0;
  int               win_ptr = 0;
  bit               new_job = 1'b0;
  bit               win_en = 1'b0;
  bit               w_en = 1'b0;
  bit               force_ov = 1'b0;
  logic             p1_v, p2_v;
  logic [OFM_W-1:0] p1_d, p2_d;

  assign win_valid     = win_en && (win_ptr < job_n);
  assign w_src_valid   = w_en;
  assign eng_out_valid = p2_v | force_ov;
  assign eng_ofm       = p2_d;

  function automatic int ref_dot(int k);
    int s = 0;
    for (int i = 0; i < NTAP; i++) s += int'(weights[i]) * int'(win_mem[k][i]);
    return s;
  endfunction

  function automatic int eng_dot(int k);
    int s = 0;
    for (int i = 0; i < NTAP; i++) s += int'(eng_w[i]) * int'(win_mem[k][i]);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0;
      p2_v <= 1'b0;
      p1_d <= '0;
      p2_d <= '0;
    end else begin
      if (eng_weight_valid) for (int i = 0; i < NTAP; i++) eng_w[i] <= weights[i];
      p1_v <= eng_in_valid;
      p1_d <= eng_in_valid ? OFM_W'(eng_dot(win_ptr)) : '0;
      p2_v <= p1_v;
      p2_d <= p1_d;
    end
  end

  always @(posedge clk) begin
    if (new_job) win_ptr <= 0;
    else if (win_valid && win_ready) win_ptr <= win_ptr + 1;
  end

  // Observation at mid-cycle
  int cyc = 0;
  int start_cyc = 0;
  int w_cnt, in_cnt, busy_cnt, done_cnt, done_cyc, first_iss, last_iss, first_res, last_pop;
  int pop_idx[$];
  int pop_dat[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eng_weight_valid) w_cnt++;
    if (eng_in_valid) begin
      if (in_cnt == 0) first_iss = cyc;
      in_cnt++;
      last_iss = cyc;
    end
    if (res_valid && first_res < 0) first_res = cyc;
    if (res_valid && res_ready) begin
      pop_idx.push_back(int'(res_idx));
      pop_dat.push_back(int'(res_data));
      last_pop = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  task automatic clear_mon();
    w_cnt = 0; in_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_iss = -1; last_iss = -1; first_res = -1; last_pop = -1;
    pop_idx.delete();
    pop_dat.delete();
  endtask

  task automatic start_job(input int n);
    for (int i = 0; i < NTAP; i++) weights[i] = 4'($urandom);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < NTAP; i++) win_mem[k][i] = 4'($urandom);
    job_n = n;
    @(posedge clk); #1;
    clear_mon();
    start = 1'b1; num_win = CNT_W'(n); new_job = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; num_win = CNT_W'($urandom); new_job = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int budget, input int rr_pct,
                                input int vv_pct, input bit repulse);
    int  k = 0;
    bit  pulsed = 1'b0;
    while (done_cnt == 0 && k < budget) begin
      res_ready = ($urandom_range(99) < rr_pct);
      win_en    = ($urandom_range(99) < vv_pct);
      w_en      = ($urandom_range(99) < vv_pct);
      if (repulse && !pulsed && in_cnt >= 1) begin
        start = 1'b1; num_win = CNT_W'(5); pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    tests_run++;
    if (done_cnt == 0) begin
      tests_failed++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic verify_job(input string name, input int n);
    int bad = 0;
    int bad_k = -1;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (pop_idx.size() != n) begin
      tests_failed++;
      $display("FAIL %s result_count: got %0d expected %0d", name, pop_idx.size(), n);
    end
    for (int k = 0; k < pop_idx.size() && k < n; k++)
      if (pop_idx[k] != k || pop_dat[k] != ref_dot(k)) begin
        bad++;
        if (bad_k < 0) bad_k = k;
      end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL %s result_order: entry %0d got idx %0d data %0d expected idx %0d data %0d (%0d bad)",
               name, bad_k, pop_idx[bad_k], pop_dat[bad_k], bad_k, ref_dot(bad_k), bad);
    end
    tests_run++;
    if (w_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s weight_loads: got %0d expected 1", name, w_cnt);
    end
    tests_run++;
    if (in_cnt != n) begin
      tests_failed++;
      $display("FAIL %s window_issues: got %0d expected %0d", name, in_cnt, n);
    end
    tests_run++;
    if (err !== 1'b0 || done_cnt != 1 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s end_state: got err=%b done_pulses=%0d res_valid=%b expected 0,1,0",
               name, err, done_cnt, res_valid);
    end
    tests_run++;
    if (busy_cnt != done_cyc - start_cyc || done_cyc <= last_pop) begin
      tests_failed++;
      $display("FAIL %s busy_done_timing: got busy_cycles=%0d done_cyc=%0d last_pop=%0d expected busy_cycles=%0d and done after last pop",
               name, busy_cnt, done_cyc, last_pop, done_cyc - start_cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #17;
    tests_run++;
    if ({busy, done, err, w_src_ready, win_ready, eng_weight_valid, eng_in_valid,
         res_valid, res_data, res_idx} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got nonzero outputs busy=%b done=%b err=%b res_valid=%b expected all 0",
               busy, done, err, res_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({busy, done, err, w_src_ready, win_ready, res_valid} !== '0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got busy=%b done=%b err=%b w_ready=%b win_ready=%b res_valid=%b expected all 0",
               busy, done, err, w_src_ready, win_ready, res_valid);
    end
  endtask

  task automatic test_zero_job();
    win_en = 1'b1; w_en = 1'b1; res_ready = 1'b1;
    start_job(0);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (done_cyc != start_cyc + 1 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL zero_job_done: got done_cyc=%0d pulses=%0d expected done_cyc=%0d pulses=1",
               done_cyc, done_cnt, start_cyc + 1);
    end
    tests_run++;
    if (w_cnt != 0 || in_cnt != 0 || busy_cnt != 0) begin
      tests_failed++;
      $display("FAIL zero_job_quiet: got weight=%0d issue=%0d busy_cycles=%0d expected 0,0,0",
               w_cnt, in_cnt, busy_cnt);
    end
  endtask

  task automatic test_basic3();
    start_job(3);
    run_until_done("basic3", 100, 100, 100, 1'b0);
    verify_job("basic3", 3);
    tests_run++;
    if (last_iss - first_iss != 2 || first_res - first_iss != ENG_LAT + 1) begin
      tests_failed++;
      $display("FAIL basic3_timing: got issue_span=%0d latency=%0d expected 2 and %0d",
               last_iss - first_iss, first_res - first_iss, ENG_LAT + 1);
    end
  endtask

  task automatic test_backpressure();
    start_job(8);
    res_ready = 1'b0; win_en = 1'b1; w_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (in_cnt != FIFO_DEPTH || win_ready !== 1'b0 || err !== 1'b0 || res_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_stall: got issues=%0d win_ready=%b err=%b res_valid=%b expected %0d,0,0,1",
               in_cnt, win_ready, err, res_valid, FIFO_DEPTH);
    end
    run_until_done("backpressure", 200, 100, 100, 1'b0);
    verify_job("backpressure", 8);
  endtask

  task automatic test_start_ignored();
    start_job(9);
    run_until_done("restart_ignored", 400, 50, 80, 1'b1);
    verify_job("restart_ignored", 9);
  endtask

  task automatic test_reset_mid_job();
    int k = 0;
    start_job(8);
    res_ready = 1'b1; win_en = 1'b1; w_en = 1'b1;
    while (in_cnt < 2 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, err, w_src_ready, win_ready, eng_weight_valid, eng_in_valid,
         res_valid, res_data, res_idx} !== '0 || in_cnt < 2) begin
      tests_failed++;
      $display("FAIL midjob_reset: got busy=%b win_ready=%b eng_in=%b res_valid=%b issues=%0d expected all outputs 0 after >=2 issues",
               busy, win_ready, eng_in_valid, res_valid, in_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    start_job(1);
    run_until_done("after_reset", 100, 100, 100, 1'b0);
    verify_job("after_reset", 1);
  endtask

  task automatic test_err_idle();
    @(posedge clk); #1;
    clear_mon();
    force_ov = 1'b1;
    @(posedge clk); #1;
    force_ov = 1'b0;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_set: got %b expected 1", err);
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (err !== 1'b1 || first_res >= 0) begin
      tests_failed++;
      $display("FAIL err_sticky: got err=%b res_valid_seen=%0d expected err=1 and res_valid never high",
               err, first_res >= 0);
    end
    rst_n = 1'b0;
    #3;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_cleared: got %b expected 0", err);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 6; j++) begin
      int n = $urandom_range(1, 20);
      start_job(n);
      run_until_done("random_job", n * 30 + 100, $urandom_range(30, 100), $urandom_range(40, 100), 1'b0);
      verify_job("random_job", n);
    end
    start_job(255);
    run_until_done("max_job", 2000, 100, 100, 1'b0);
    verify_job("max_job", 255);
  endtask

  initial begin
    test_reset();
    test_zero_job();
    test_basic3();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_job();
    test_err_idle();
    test_random_jobs();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
